// File: rtl/icap_write_sequencer_if.sv
// FIFO read port and ICAP write port bundled between the sequencer and its neighbours.
// master = sequencer side, slave = FIFO/ICAP side.
interface icap_write_sequencer_if #(
    parameter int DATA_SIZE  = 256,
    parameter int ICAP_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_SIZE-1:0]  fifo_data;
    logic [ICAP_WIDTH-1:0] icap_data;
    logic                  icap_csib;
    logic                  icap_rdwrb;

    modport master (
        input  fifo_empty, fifo_data,
        output fifo_rd_en, icap_data, icap_csib, icap_rdwrb
    );

    modport slave (
        output fifo_empty, fifo_data,
        input  fifo_rd_en, icap_data, icap_csib, icap_rdwrb
    );
endinterface

// File: rtl/icap_write_sequencer.sv
// Drains wide configuration words from the bitstream FIFO and writes each one to
// the ICAP as consecutive 32-bit beats, with stall supervision and abort.
module icap_write_sequencer #(
    parameter int DATA_SIZE   = 256,
    parameter int ICAP_WIDTH  = 32,
    parameter int BITSWAP     = 1,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             word_count,
    input  logic                    abort,
    icap_write_sequencer_if.master  bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             words_sent
);
    localparam int BEATS = DATA_SIZE / ICAP_WIDTH;
    localparam int BW    = $clog2(BEATS);
    localparam int SW    = $clog2(STALL_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, REQ, LATCH, SHIFT, FINISH} state_t;

    state_t                state, state_n;
    logic [DATA_SIZE-1:0]  shreg, shreg_n;
    logic [31:0]           remaining, remaining_n, words_sent_n;
    logic [BW-1:0]         beat, beat_n;
    logic [SW-1:0]         stall, stall_n;
    logic                  rd_en_n, csib_n, busy_n, done_n, error_n;
    logic [ICAP_WIDTH-1:0] data_n, beat_word, beat_swapped;

    // The shift register is consumed from the bottom, so the current beat is always the low slice.
    assign beat_word = shreg[ICAP_WIDTH-1:0];

    always_comb begin
        beat_swapped = beat_word;
        if (BITSWAP != 0) begin
            for (int b = 0; b < ICAP_WIDTH / 8; b++)
                for (int i = 0; i < 8; i++)
                    beat_swapped[8*b+i] = beat_word[8*b+7-i];
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        remaining_n  = remaining;
        words_sent_n = words_sent;
        beat_n       = beat;
        stall_n      = stall;
        rd_en_n      = 1'b0;
        csib_n       = 1'b1;
        data_n       = bus.icap_data;
        busy_n       = busy;
        done_n       = 1'b0;
        error_n      = error;

        case (state)
            IDLE: begin
                if (start) begin
                    error_n      = 1'b0;
                    words_sent_n = 32'd0;
                    if (word_count != 32'd0) begin
                        remaining_n = word_count;
                        stall_n     = '0;
                        busy_n      = 1'b1;
                        state_n     = REQ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            REQ: begin
                if (!bus.fifo_empty) begin
                    rd_en_n = 1'b1;
                    stall_n = '0;
                    state_n = LATCH;
                end else if (stall == SW'(STALL_LIMIT - 1)) begin
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    stall_n = '0;
                    state_n = IDLE;
                end else begin
                    stall_n = stall + SW'(1);
                end
            end
            LATCH: begin
                shreg_n = bus.fifo_data;
                beat_n  = '0;
                state_n = SHIFT;
            end
            SHIFT: begin
                csib_n  = 1'b0;
                data_n  = beat_swapped;
                shreg_n = shreg >> ICAP_WIDTH;
                beat_n  = beat + BW'(1);
                if (beat == BW'(BEATS - 1)) begin
                    if (words_sent != '1)
                        words_sent_n = words_sent + 32'd1;
                    remaining_n = remaining - 32'd1;
                    state_n     = (remaining == 32'd1) ? FINISH : REQ;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides everything, including a coincident stall timeout or word completion.
        if (abort && state != IDLE) begin
            state_n      = IDLE;
            rd_en_n      = 1'b0;
            csib_n       = 1'b1;
            error_n      = 1'b1;
            busy_n       = 1'b0;
            done_n       = 1'b0;
            stall_n      = '0;
            words_sent_n = words_sent;
            remaining_n  = remaining;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            remaining      <= 32'd0;
            words_sent     <= 32'd0;
            beat           <= '0;
            stall          <= '0;
            bus.fifo_rd_en <= 1'b0;
            bus.icap_csib  <= 1'b1;
            bus.icap_rdwrb <= 1'b1;
            bus.icap_data  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            shreg          <= shreg_n;
            remaining      <= remaining_n;
            words_sent     <= words_sent_n;
            beat           <= beat_n;
            stall          <= stall_n;
            bus.fifo_rd_en <= rd_en_n;
            bus.icap_csib  <= csib_n;
            bus.icap_rdwrb <= ~busy_n;
            bus.icap_data  <= data_n;
            busy           <= busy_n;
            done           <= done_n;
            error          <= error_n;
        end
    end
endmodule
